// File: rtl/tamagotchi_pkg.sv
// Shared pet-state encodings and defaults for the Tamagotchi controller and animation blocks.
package tamagotchi_pkg;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        DORMINDO      = 3'd1,
        ACORDANDO     = 3'd2,
        COMENDO       = 3'd3,
        LIMPANDO_BOCA = 3'd4,
        DANDO_AULA    = 3'd5,
        VOLTANDO      = 3'd6,
        MORTO         = 3'd7
    } estado_t;

    localparam int PASSO_REC_DEF = 2;

endpackage

// File: rtl/gerador_tick.sv
// Free-running game-tick divider: one-cycle strobe every TICK_DIV clk cycles after reset.
module gerador_tick #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q;
    logic             last;

    always_comb begin
        last  = (cnt_q == CNT_LAST);
        cnt_d = last ? '0 : cnt_q + 1'b1;
    end

    // Strobe is registered so it appears exactly TICK_DIV edges after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= last;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/controlador_tamagotchi.sv
// Main pet controller: state FSM, saturating need counters, timed animation exits and death.
// Optional CONTROLADOR_AUTO_DESPERTAR_EN: pet wakes by itself once sono drains to 0.
module controlador_tamagotchi
    import tamagotchi_pkg::*;
#(
    parameter int STAT_W     = 8,
    parameter int TICK_DIV   = 50_000_000,
    parameter int ANIM_TICKS = 4,
    parameter int PASSO_REC  = PASSO_REC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              b1,
    input  logic              b2,
    output logic [2:0]        estado,
    output logic [STAT_W-1:0] fome,
    output logic [STAT_W-1:0] felicidade,
    output logic [STAT_W-1:0] sono,
    output logic              tick,
    output logic              morto
);

    localparam logic [STAT_W-1:0] STAT_MAX = '1;
    localparam logic [STAT_W-1:0] STEP     = STAT_W'(PASSO_REC);
    localparam logic [STAT_W-1:0] ONE      = STAT_W'(1);
    localparam int                ANIM_W   = $clog2(ANIM_TICKS + 1);
    localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_TICKS - 1);

    estado_t           state_q, state_d;
    logic [STAT_W-1:0] fome_q, fome_d;
    logic [STAT_W-1:0] sono_q, sono_d;
    logic [STAT_W-1:0] feli_q, feli_d;
    logic [ANIM_W-1:0] anim_q, anim_d;
    logic              is_anim;
    logic              anim_done;
    logic              dying;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                  input logic [STAT_W-1:0] s);
        logic [STAT_W:0] sum;
        sum = {1'b0, v} + {1'b0, s};
        return sum[STAT_W] ? STAT_MAX : sum[STAT_W-1:0];
    endfunction

    function automatic logic [STAT_W-1:0] sat_dec(input logic [STAT_W-1:0] v,
                                                  input logic [STAT_W-1:0] s);
        return (v < s) ? '0 : v - s;
    endfunction

    gerador_tick #(.TICK_DIV(TICK_DIV)) u_gerador_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        fome_d    = fome_q;
        sono_d    = sono_q;
        feli_d    = feli_q;
        anim_d    = anim_q;
        is_anim   = (state_q == ACORDANDO) || (state_q == LIMPANDO_BOCA) || (state_q == VOLTANDO);
        anim_done = tick && (anim_q == ANIM_LAST);
        dying     = (fome_q == STAT_MAX) || (sono_q == STAT_MAX) || (feli_q == '0);

        if (state_q != MORTO) begin
            // Death outranks every button and animation exit.
            if (dying) begin
                state_d = MORTO;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (b1 && b2)  state_d = DANDO_AULA;
                        else if (b1)   state_d = COMENDO;
                        else if (b2)   state_d = DORMINDO;
                    end
                    DORMINDO: begin
`ifdef CONTROLADOR_AUTO_DESPERTAR_EN
                        if (b2 || (sono_q == '0)) state_d = ACORDANDO;
`else
                        if (b2) state_d = ACORDANDO;
`endif
                    end
                    COMENDO:    if (b1) state_d = LIMPANDO_BOCA;
                    DANDO_AULA: if (b1 && b2) state_d = VOLTANDO;
                    ACORDANDO, LIMPANDO_BOCA, VOLTANDO: if (anim_done) state_d = IDLE;
                    default: ;
                endcase
            end

            // Counters follow the state held during the tick, not the one being entered.
            if (tick) begin
                fome_d = (state_q == COMENDO)    ? sat_dec(fome_q, STEP) : sat_inc(fome_q, ONE);
                sono_d = (state_q == DORMINDO)   ? sat_dec(sono_q, STEP) : sat_inc(sono_q, ONE);
                feli_d = (state_q == DANDO_AULA) ? sat_inc(feli_q, STEP) : sat_dec(feli_q, ONE);
            end
        end

        if (state_d != state_q)   anim_d = '0;
        else if (tick && is_anim) anim_d = anim_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            fome_q  <= '0;
            sono_q  <= '0;
            feli_q  <= STAT_MAX;
            anim_q  <= '0;
        end else begin
            state_q <= state_d;
            fome_q  <= fome_d;
            sono_q  <= sono_d;
            feli_q  <= feli_d;
            anim_q  <= anim_d;
        end
    end

    assign estado     = state_q;
    assign fome       = fome_q;
    assign sono       = sono_q;
    assign felicidade = feli_q;
    assign morto      = (state_q == MORTO);

endmodule

// File: tb/tb_controlador_tamagotchi.sv
// Self-checking bench for controlador_tamagotchi: vector table, corner sequences, random run vs model.
module tb_controlador_tamagotchi;

    localparam int SW   = 4;
    localparam int TD   = 4;
    localparam int AT   = 2;
    localparam int PR   = 2;
    localparam int MAXV = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          b1  = 1'b0;
    logic          b2  = 1'b0;
    logic [2:0]    estado;
    logic [SW-1:0] fome, felicidade, sono;
    logic          tick, morto;

    int total = 0;
    int bad   = 0;

    // Reference model: plain integers, tick derived from elapsed cycles.
    int m_cyc, m_st, m_fome, m_sono, m_feli, m_anim;

    typedef struct packed {
        logic       b1;
        logic       b2;
        logic [2:0] exp_st;
    } vec_t;
    vec_t tbl[29];

    controlador_tamagotchi #(
        .STAT_W(SW), .TICK_DIV(TD), .ANIM_TICKS(AT), .PASSO_REC(PR)
    ) dut (
        .clk(clk), .rst(rst), .b1(b1), .b2(b2),
        .estado(estado), .fome(fome), .felicidade(felicidade), .sono(sono),
        .tick(tick), .morto(morto)
    );

    always #5 clk = ~clk;

    function automatic bit m_tick();
        return (m_cyc > 0) && (m_cyc % TD == 0);
    endfunction

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > MAXV) return MAXV;
        return v;
    endfunction

    task automatic model_step(input bit b1v, input bit b2v, input bit rv);
        int nst;
        bit t;
        if (rv) begin
            m_cyc = 0; m_st = 0; m_fome = 0; m_sono = 0; m_feli = MAXV; m_anim = 0;
            return;
        end
        t   = m_tick();
        nst = m_st;
        if (m_st != 7) begin
            if (m_fome == MAXV || m_sono == MAXV || m_feli == 0) nst = 7;
            else if (m_st == 0) begin
                if (b1v && b2v) nst = 5;
                else if (b1v)   nst = 3;
                else if (b2v)   nst = 1;
            end else if (m_st == 1) begin
`ifdef CONTROLADOR_AUTO_DESPERTAR_EN
                if (b2v || m_sono == 0) nst = 2;
`else
                if (b2v) nst = 2;
`endif
            end else if (m_st == 3) begin
                if (b1v) nst = 4;
            end else if (m_st == 5) begin
                if (b1v && b2v) nst = 6;
            end else if (t && (m_anim + 1 >= AT)) begin
                nst = 0;
            end
            if (t) begin
                m_fome = clamp((m_st == 3) ? m_fome - PR : m_fome + 1);
                m_sono = clamp((m_st == 1) ? m_sono - PR : m_sono + 1);
                m_feli = clamp((m_st == 5) ? m_feli + PR : m_feli - 1);
            end
        end
        if (nst != m_st) m_anim = 0;
        else if (t && (m_st == 2 || m_st == 4 || m_st == 6)) m_anim++;
        m_st = nst;
        m_cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("estado",     32'(estado),     m_st);
        chk("fome",       32'(fome),       m_fome);
        chk("sono",       32'(sono),       m_sono);
        chk("felicidade", 32'(felicidade), m_feli);
        chk("tick",       32'(tick),       int'(m_tick()));
        chk("morto",      32'(morto),      int'(m_st == 7));
    endtask

    // One clock: drive at negedge, advance model at posedge, compare at next negedge.
    task automatic step(input bit b1v, input bit b2v, input bit rv);
        b1 = b1v; b2 = b2v; rst = rv;
        @(posedge clk);
        model_step(b1v, b2v, rv);
        @(negedge clk);
        b1 = 1'b0; b2 = 1'b0; rst = 1'b0;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int nt;
        tbl[0]  = '{1'b1, 1'b0, 3'd3};  tbl[1]  = '{1'b0, 1'b1, 3'd3};
        tbl[2]  = '{1'b0, 1'b0, 3'd3};  tbl[3]  = '{1'b1, 1'b0, 3'd4};
        tbl[4]  = '{1'b1, 1'b0, 3'd4};  tbl[5]  = '{1'b0, 1'b0, 3'd4};
        tbl[6]  = '{1'b0, 1'b0, 3'd4};  tbl[7]  = '{1'b0, 1'b0, 3'd4};
        tbl[8]  = '{1'b0, 1'b0, 3'd0};  tbl[9]  = '{1'b1, 1'b1, 3'd5};
        tbl[10] = '{1'b1, 1'b0, 3'd5};  tbl[11] = '{1'b0, 1'b1, 3'd5};
        tbl[12] = '{1'b1, 1'b1, 3'd6};
        for (int i = 13; i < 20; i++) tbl[i] = '{1'b0, 1'b0, 3'd6};
        tbl[20] = '{1'b0, 1'b0, 3'd0};  tbl[21] = '{1'b0, 1'b1, 3'd1};
        tbl[22] = '{1'b1, 1'b0, 3'd1};  tbl[23] = '{1'b0, 1'b1, 3'd2};
        for (int i = 24; i < 28; i++) tbl[i] = '{1'b0, 1'b0, 3'd2};
        tbl[28] = '{1'b0, 1'b0, 3'd0};

        @(negedge clk);

        // Reset values and the first 16 idle cycles.
        step(1'b0, 1'b0, 1'b1);
        chk("rst_estado", 32'(estado), 0);
        chk("rst_fome", 32'(fome), 0);
        chk("rst_sono", 32'(sono), 0);
        chk("rst_feli", 32'(felicidade), MAXV);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_morto", 32'(morto), 0);
        nt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0);
            nt += int'(tick);
        end
        chk("tick_count16", 32'(nt), 4);
        step(1'b0, 1'b0, 1'b0);
        chk("idle_fome", 32'(fome), 4);
        chk("idle_sono", 32'(sono), 4);
        chk("idle_feli", 32'(felicidade), 11);
        chk("idle_estado", 32'(estado), 0);

        // Button/animation walk from reset.
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 29; i++) begin
            step(tbl[i].b1, tbl[i].b2, 1'b0);
            chk($sformatf("tbl_estado[%0d]", i), 32'(estado), int'(tbl[i].exp_st));
        end

        // Felicidade saturates at the top while teaching.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("aula_estado", 32'(estado), 5);
        idle(8);
        chk("aula_feli_sat", 32'(felicidade), MAXV);
        chk("aula_fome", 32'(fome), 2);
        step(1'b1, 1'b1, 1'b0);
        chk("aula_voltando", 32'(estado), 6);

        // Starvation: death one cycle after the counters hit their limits.
        step(1'b0, 1'b0, 1'b1);
        idle(61);
        chk("pre_morto", 32'(morto), 0);
        chk("pre_fome", 32'(fome), MAXV);
        step(1'b0, 1'b0, 1'b0);
        chk("morto", 32'(morto), 1);
        chk("morto_estado", 32'(estado), 7);
        for (int i = 0; i < 12; i++) step(1'(i % 2), 1'(i % 3 == 0), 1'b0);
        chk("morto_fome", 32'(fome), MAXV);
        chk("morto_sono", 32'(sono), MAXV);
        chk("morto_feli", 32'(felicidade), 0);
        chk("morto_hold", 32'(estado), 7);
        step(1'b0, 1'b0, 1'b1);
        chk("revive_estado", 32'(estado), 0);
        chk("revive_fome", 32'(fome), 0);
        chk("revive_feli", 32'(felicidade), MAXV);

        // Sleep drains sono to zero; wake-up depends on the build option.
        idle(13);
        chk("sleep_sono3", 32'(sono), 3);
        step(1'b0, 1'b1, 1'b0);
        chk("sleep_enter", 32'(estado), 1);
        idle(7);
        chk("sleep_sono0", 32'(sono), 0);
        chk("sleep_still", 32'(estado), 1);
        step(1'b0, 1'b0, 1'b0);
`ifdef CONTROLADOR_AUTO_DESPERTAR_EN
        chk("auto_wake", 32'(estado), 2);
`else
        chk("no_auto_wake", 32'(estado), 1);
        idle(4);
        chk("sleep_hold", 32'(estado), 1);
        chk("sleep_sono_floor", 32'(sono), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("b2_wake", 32'(estado), 2);
`endif

        // Tick and b2 on the same edge in IDLE.
        step(1'b0, 1'b0, 1'b1);
        idle(4);
        chk("tick_at4", 32'(tick), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("tickb2_estado", 32'(estado), 1);
        chk("tickb2_sono", 32'(sono), 1);

        // Random run against the model, with occasional resets.
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
